// File: rtl/apb_master_bridge_if.sv
// Bundle of the request/response handshake and the APB bus that the bridge sits between.
// The master modport is the bridge's view; the slave modport is the requester plus completers.
interface apb_master_bridge_if #(
    parameter int NUM_SLV = 4
);
    logic                    req_valid;
    logic                    req_write;
    logic [31:0]             req_addr;
    logic [31:0]             req_wdata;
    logic                    req_ready;
    logic                    rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;

    logic [31:0]             PADDR;
    logic                    PWRITE;
    logic [31:0]             PWDATA;
    logic                    PENABLE;
    logic [NUM_SLV-1:0]      PSEL;
    logic [32*NUM_SLV-1:0]   PRDATA;
    logic [NUM_SLV-1:0]      PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-request APB master: decodes a 4 KiB completer slot, runs SETUP/ACCESS with a
// wait-state timeout, and returns a one-cycle response pulse with registered data/error.
module apb_master_bridge #(
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_bridge_if.master  bus
);
    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state_q;
    logic [3:0]           slot_q;
    logic [CW-1:0]        cnt_q;
    logic [31:0]          paddr_q;
    logic                 pwrite_q;
    logic [31:0]          pwdata_q;
    logic                 penable_q;
    logic [NUM_SLV-1:0]   psel_q;
    logic                 rsp_valid_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_err_q;

    logic [3:0]           slot_d;
    logic                 addr_ok_d;
    logic [NUM_SLV-1:0]   psel_d;
    logic                 pready_sel;
    logic [31:0]          prdata_sel;

    // Decode of the incoming request, plus the completer mux for the latched slot.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        slot_d     = bus.req_addr[15:12];
        addr_ok_d  = (bus.req_addr[31:16] == 16'h1000) && ({1'b0, slot_d} < 5'(NUM_SLV));
        psel_d     = '0;
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slot_d == 4'(i)) psel_d[i] = 1'b1;
            if (slot_q == 4'(i)) begin
                pready_sel = bus.PREADY[i];
                prdata_sel = bus.PRDATA[32*i +: 32];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking only; this default turns rsp_valid into a single-cycle pulse.
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (addr_ok_d) begin
                            paddr_q  <= bus.req_addr;
                            pwrite_q <= bus.req_write;
                            pwdata_q <= bus.req_wdata;
                            slot_q   <= slot_d;
                            psel_q   <= psel_d;
                            state_q  <= SETUP;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer wins even on the last allowed cycle.
                    if (pready_sel || (cnt_q == CNT_LAST)) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !pready_sel;
                        rsp_rdata_q <= (pready_sel && !pwrite_q) ? prdata_sel : '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated with PRESET so the requester sees ready drop the instant reset asserts.
    assign bus.req_ready = (state_q == IDLE) && PRESET;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PSEL      = psel_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: each accepted request is expanded into a per-cycle schedule of
// expected bus/response values, compared against the DUT on every cycle.
module tb_apb_master_bridge;
    localparam int NS = 4;
    localparam int TO = 16;

    typedef struct {
        logic          rr;
        logic [NS-1:0] psel;
        logic          pen;
        logic          rv;
        logic [31:0]   paddr;
        logic          pwrite;
        logic [31:0]   pwdata;
        logic [31:0]   rdata;
        logic          err;
        bit            has_slot;
        int            slot;
        logic          rdy;
        logic [31:0]   rd;
    } cyc_t;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          w;
    } req_t;

    logic PCLK;
    logic PRESET;

    apb_master_bridge_if #(.NUM_SLV(NS)) bus ();

    apb_master_bridge #(.NUM_SLV(NS), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    cyc_t exp_q[$];
    cyc_t last_rec;
    req_t pend;
    bit   pend_v     = 0;
    bit   others_ones = 0;

    logic [31:0]   m_paddr = '0, m_pwdata = '0, m_rdata = '0;
    logic          m_pwrite = 1'b0, m_err = 1'b0;

    int            acc_cyc = 0, rsp_cyc = -1, pen_cnt = 0;
    logic [NS-1:0] psel_or = '0;
    logic [31:0]   cap_rdata = '0;
    logic          cap_err = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic cyc_t idle_rec();
        cyc_t r;
        r.rr = 1'b1;  r.psel = '0;  r.pen = 1'b0;  r.rv = 1'b0;
        r.paddr = m_paddr;  r.pwrite = m_pwrite;  r.pwdata = m_pwdata;
        r.rdata = m_rdata;  r.err = m_err;
        r.has_slot = 0;  r.slot = 0;  r.rdy = 1'b0;  r.rd = '0;
        return r;
    endfunction

    // Expand one accepted request into the cycles that follow its accepting edge.
    task automatic plan(req_t p);
        cyc_t r;
        int   slot = int'(p.addr[15:12]);
        bit   ok_addr = (p.addr[31:16] == 16'h1000) && (slot < NS);
        bit   done = (p.w < TO);
        int   n = done ? p.w + 1 : TO;
        r = idle_rec();
        r.rr = 1'b0;
        if (ok_addr) begin
            m_paddr = p.addr;  m_pwrite = p.write;  m_pwdata = p.wdata;
            r.paddr = m_paddr; r.pwrite = m_pwrite; r.pwdata = m_pwdata;
            r.psel = '0;  r.psel[slot] = 1'b1;
            r.has_slot = 1;  r.slot = slot;  r.rd = p.rd;
            r.rdy = 1'($urandom_range(0, 1));
            exp_q.push_back(r);
            r.pen = 1'b1;
            for (int j = 0; j < n; j++) begin
                r.rdy = done && (j >= p.w);
                exp_q.push_back(r);
            end
            m_rdata = (done && !p.write) ? p.rd : 32'h0;
            m_err   = !done;
        end else begin
            m_rdata = 32'h0;
            m_err   = 1'b1;
        end
        r.psel = '0;  r.pen = 1'b0;  r.rv = 1'b1;  r.has_slot = 0;
        r.rdata = m_rdata;  r.err = m_err;
        exp_q.push_back(r);
    endtask

    task automatic check_cycle(cyc_t e);
        check("req_ready", 32'(bus.req_ready), 32'(e.rr));
        check("PSEL",      32'(bus.PSEL),      32'(e.psel));
        check("PENABLE",   32'(bus.PENABLE),   32'(e.pen));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e.rv));
        check("PADDR",     bus.PADDR,          e.paddr);
        check("PWRITE",    32'(bus.PWRITE),    32'(e.pwrite));
        check("PWDATA",    bus.PWDATA,         e.pwdata);
        check("rsp_rdata", bus.rsp_rdata,      e.rdata);
        check("rsp_err",   32'(bus.rsp_err),   32'(e.err));
    endtask

    // One clock: compare, observe, then drive completer and requester for this cycle.
    task automatic step();
        cyc_t              cur;
        logic [NS-1:0]     rdy;
        logic [32*NS-1:0]  prd;
        @(posedge PCLK);
        #1;
        cyc++;
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
        last_rec = cur;
        check_cycle(cur);
        if (bus.rsp_valid) begin
            rsp_cyc = cyc;  cap_rdata = bus.rsp_rdata;  cap_err = bus.rsp_err;
        end
        psel_or |= bus.PSEL;
        if (bus.PENABLE) pen_cnt++;
        for (int i = 0; i < NS; i++) begin
            rdy[i] = others_ones ? 1'b1 : 1'($urandom_range(0, 1));
            prd[32*i +: 32] = $urandom;
        end
        if (cur.has_slot) begin
            rdy[cur.slot] = cur.rdy;
            prd[32*cur.slot +: 32] = cur.rd;
        end
        bus.PREADY = rdy;
        bus.PRDATA = prd;
        if (pend_v) begin
            bus.req_valid = 1'b1;  bus.req_write = pend.write;
            bus.req_addr  = pend.addr;  bus.req_wdata = pend.wdata;
            if (cur.rr) begin
                plan(pend);
                pend_v = 0;  acc_cyc = cyc;  rsp_cyc = -1;  psel_or = '0;  pen_cnt = 0;
            end
        end else if (cur.rr) begin
            bus.req_valid = 1'b0;
        end else begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = {16'h1000, 4'($urandom_range(0, 3)), 12'($urandom)};
            bus.req_wdata = $urandom;
        end
    endtask

    task automatic run_req(logic wr, logic [31:0] addr, logic [31:0] wd, logic [31:0] rd, int w);
        bit fin = 0;
        pend = '{write: wr, addr: addr, wdata: wd, rd: rd, w: w};
        pend_v = 1;
        for (int n = 0; n < 200 && !fin; n++) begin
            step();
            fin = !pend_v && (exp_q.size() == 0);
        end
        if (!fin) check("req_completes", 32'(0), 32'(1));
    endtask

    task automatic wait_accept();
        for (int n = 0; n < 100 && pend_v; n++) step();
        if (pend_v) check("accept_bound", 32'(0), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        PRESET = 1'b0;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
        bus.PREADY = '0;  bus.PRDATA = '0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_PSEL",      32'(bus.PSEL),      32'(0));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_PADDR",     bus.PADDR,          32'h0);
        repeat (2) @(posedge PCLK);
        #3;
        PRESET = 1'b1;
        #1;
        check("first_cycle_ready", 32'(bus.req_ready), 32'(1));

        run_req(1'b1, 32'h1000_0004, 32'h0000_000F, 32'h0, 0);
        check("wr0_latency", 32'(rsp_cyc - acc_cyc), 32'(3));
        check("wr0_pen_cycles", 32'(pen_cnt), 32'(1));
        check("wr0_psel", 32'(psel_or), 32'(4'b0001));
        check("wr0_pwdata", bus.PWDATA, 32'h0000_000F);
        check("wr0_err", 32'(cap_err), 32'(0));
        check("wr0_rdata", cap_rdata, 32'h0);

        run_req(1'b0, 32'h1000_2008, 32'h0, 32'hCAFE_0001, 3);
        check("rd2_pen_cycles", 32'(pen_cnt), 32'(4));
        check("rd2_rdata", cap_rdata, 32'hCAFE_0001);
        check("rd2_err", 32'(cap_err), 32'(0));
        check("rd2_psel", 32'(psel_or), 32'(4'b0100));

        run_req(1'b0, 32'h2000_0000, 32'h0, 32'h1234_5678, 0);
        check("bad_hi_latency", 32'(rsp_cyc - acc_cyc), 32'(1));
        check("bad_hi_psel", 32'(psel_or), 32'(0));
        check("bad_hi_err", 32'(cap_err), 32'(1));
        check("bad_hi_rdata", cap_rdata, 32'h0);
        run_req(1'b0, 32'h1000_5000, 32'h0, 32'h1234_5678, 0);
        check("bad_slot_latency", 32'(rsp_cyc - acc_cyc), 32'(1));
        check("bad_slot_psel", 32'(psel_or), 32'(0));
        check("bad_slot_err", 32'(cap_err), 32'(1));

        run_req(1'b0, 32'h1000_1000, 32'h0, 32'h5555_AAAA, TO);
        check("tmo_pen_cycles", 32'(pen_cnt), 32'(TO));
        check("tmo_err", 32'(cap_err), 32'(1));
        check("tmo_rdata", cap_rdata, 32'h0);
        run_req(1'b0, 32'h1000_1010, 32'h0, 32'h0BAD_F00D, 1);
        check("post_tmo_err", 32'(cap_err), 32'(0));
        check("post_tmo_rdata", cap_rdata, 32'h0BAD_F00D);

        // Reset pulled mid-ACCESS.
        pend = '{write: 1'b1, addr: 32'h1000_1020, wdata: 32'hDEAD_BEEF, rd: 32'h0, w: TO + 5};
        pend_v = 1;
        for (int n = 0; n < 20 && !(last_rec.pen === 1'b1); n++) step();
        check("in_access", 32'(bus.PENABLE), 32'(1));
        #3;
        PRESET = 1'b0;
        #1;
        check("async_PSEL", 32'(bus.PSEL), 32'(0));
        check("async_PENABLE", 32'(bus.PENABLE), 32'(0));
        check("async_req_ready", 32'(bus.req_ready), 32'(0));
        exp_q.delete();
        m_paddr = '0;  m_pwrite = 1'b0;  m_pwdata = '0;  m_rdata = '0;  m_err = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge PCLK);
        #1;
        check("in_rst_PADDR", bus.PADDR, 32'h0);
        check("in_rst_PWDATA", bus.PWDATA, 32'h0);
        check("in_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        #2;
        PRESET = 1'b1;
        #1;
        check("rerst_ready", 32'(bus.req_ready), 32'(1));
        run_req(1'b1, 32'h1000_3000, 32'h0000_00A5, 32'h0, 0);
        check("post_rst_err", 32'(cap_err), 32'(0));
        check("post_rst_latency", 32'(rsp_cyc - acc_cyc), 32'(3));

        // Back-to-back writes with req_valid held; slot 0 PREADY forced high during the second.
        pend = '{write: 1'b1, addr: 32'h1000_0010, wdata: 32'h1111_0000, rd: 32'h0, w: 0};
        pend_v = 1;
        wait_accept();
        a1 = acc_cyc;
        others_ones = 1;
        run_req(1'b1, 32'h1000_3010, 32'h2222_0003, 32'h0, 2);
        others_ones = 0;
        check("b2b_accept_gap", 32'(acc_cyc - a1), 32'(4));
        check("b2b_psel", 32'(psel_or), 32'(4'b1000));
        check("b2b_pen_cycles", 32'(pen_cnt), 32'(3));
        check("b2b_err", 32'(cap_err), 32'(0));

        for (int t = 0; t < 400; t++) begin
            logic [31:0] addr;
            int          w;
            case ($urandom_range(0, 9))
                0, 1:    addr = $urandom;
                default: addr = {16'h1000, 4'($urandom_range(0, 5)), 12'($urandom)};
            endcase
            case ($urandom_range(0, 9))
                6:       w = TO - 1;
                7:       w = TO;
                8:       w = TO + 3;
                default: w = $urandom_range(0, 3);
            endcase
            run_req(1'($urandom_range(0, 1)), addr, $urandom, $urandom, w);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
